score_input_conditioner: RTL and testbench
==========================================

Name: score_input_conditioner

Overview:
- Front-end for the scoreboard: conditions the raw push-buttons (+1, +2, +3, pause) and the team switch.
- Synchronizes and debounces each button, then emits exactly one score event per physical press, tagged with points and team.
- Maintains the debounced pause toggle.
- Feeds the score accumulator and game-clock logic directly; everything runs in the main clock domain.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles required to accept a press or release (10 ms at 100 MHz); legal range 2..2^CNT_W-1
CNT_W, 20, width of each debounce counter

Ports:
clock  input  1  system clock (100 MHz)
reset  input  1  asynchronous active-low reset
btn_one  input  1  raw +1 button, active-high, asynchronous
btn_two  input  1  raw +2 button, active-high, asynchronous
btn_three  input  1  raw +3 button, active-high, asynchronous
btn_pause  input  1  raw pause button, active-high, asynchronous
sw_team  input  1  raw team switch, asynchronous (1 = team 1, 0 = team 2)
score_valid  output  1  one-cycle pulse: accepted score event
score_pts  output  2  points of last accepted event (1, 2 or 3)
score_team  output  1  team of last accepted event
pause_level  output  1  debounced pause toggle (1 = paused)
overlap_err  output  1  one-cycle pulse: a score press was qualified but rejected

Behaviour:
- Reset (reset=0, async): all sync flops 0, all per-button FSMs IDLE, counters 0; score_valid=0, score_pts=0, score_team=0, pause_level=0, overlap_err=0. Reset asserted mid-debounce or mid-hold discards that press. After release, a button already held down must be debounced again from IDLE.
- Synchronization: each of the 5 raw inputs passes through a 2-flop synchronizer; only synchronized values are used.
- Per-button FSM (4 instances), counter cnt:
  - IDLE: sync=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: sync=0 -> IDLE. Else if cnt==DEBOUNCE_CYCLES-1 -> HELD and raise an internal press strobe for one cycle. Else cnt+1.
  - HELD: sync=0 -> RELEASE_WAIT, cnt=0. No further strobes while held (no auto-repeat).
  - RELEASE_WAIT: sync=1 -> HELD, with no strobe (bounce on release). Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else cnt+1.
- Score arbitration, evaluated each cycle on the press strobes of the three score buttons:
  - A strobe is blocked if any *other* score button is in HELD or RELEASE_WAIT; this state is checked before the cycle's transitions.
  - Among unblocked strobes in the same cycle, priority is three > two > one; only the winner is accepted.
  - If at least one strobe was dropped (blocked or lost priority), overlap_err=1 on the next cycle, independent of whether a winner exists.
- Accepted event, registered, with outputs on the cycle after the strobe:
  - score_valid=1 for exactly one cycle.
  - score_pts = 1/2/3.
  - score_team = synchronized sw_team sampled in the strobe cycle.
  - score_pts and score_team hold until the next accepted event.
- Pause: pause_level inverts on the cycle after the pause button's strobe. The pause button is independent of score arbitration and never raises overlap_err.
- Latency, from a clean rising raw edge to score_valid: 2 sync cycles + 1 IDLE->PRESS_WAIT cycle + DEBOUNCE_CYCLES + 1 output register, i.e. DEBOUNCE_CYCLES+4 clocks (±1 for async sampling).
- Counter: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- sw_team changes take effect only at strobe time; a switch toggle while a button is held does not generate an event.

Test Plan:
(all with DEBOUNCE_CYCLES=4)
- Reset: hold reset=0 with all buttons high, release -> outputs 0 and no score_valid for DEBOUNCE_CYCLES+2 cycles. Keep btn_two high -> exactly one pulse, score_pts=2.
- Clean press: sw_team=1, btn_three high for 20 cycles then low -> exactly one score_valid, 8±1 cycles after the edge, with score_pts=3, score_team=1. Values hold after release.
- Bounce on press: btn_one toggles 1,0,1,0 with 2-cycle periods, then stays high -> no event during the bounce, then one pulse with score_pts=1.
- Bounce on release: btn_two held, released for 2 cycles, high again for 10 cycles, then released -> exactly one score_valid total.
- Simultaneous and blocked presses: btn_one and btn_three rise on the same cycle -> one pulse with score_pts=3, plus an overlap_err pulse. Then, with btn_three still held, press btn_two -> no score_valid, one overlap_err pulse.
- Pause: three separate debounced btn_pause presses -> pause_level goes 1, 0, 1; score_valid stays 0 and overlap_err stays 0 throughout.

Source files
------------

// File: rtl/score_input_conditioner.sv
// Scoreboard input front-end: synchronizes and debounces the score/pause
// buttons and emits one tagged score event per accepted press.

module score_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic i_sync,
   output logic o_strobe,
   output logic o_busy
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_strobe    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_sync) begin
               w_state_nxt = PRESS_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!i_sync) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = HELD;
               w_cnt_nxt   = '0;
               o_strobe    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!i_sync) begin
               w_state_nxt = RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            // a high sample here is release bounce: back to HELD, no strobe
            if (i_sync) begin
               w_state_nxt = HELD;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_busy = (r_state == HELD) || (r_state == RELEASE_WAIT);

endmodule

module score_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_one,
   input  logic       btn_two,
   input  logic       btn_three,
   input  logic       btn_pause,
   input  logic       sw_team,
   output logic       score_valid,
   output logic [1:0] score_pts,
   output logic       score_team,
   output logic       pause_level,
   output logic       overlap_err
);

   logic [4:0] w_raw;
   logic [4:0] r_sync1;
   logic [4:0] r_sync2;
   logic [3:0] w_strobe;
   logic [3:0] w_busy;
   logic [2:0] w_blocked;
   logic [2:0] w_live;
   logic [2:0] w_win;
   logic [1:0] w_pts;
   logic       w_drop;

   logic       r_valid;
   logic [1:0] r_pts;
   logic       r_team;
   logic       r_pause;
   logic       r_ovl;

   assign w_raw = {sw_team, btn_pause, btn_three, btn_two, btn_one};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_btn
      score_btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clock   (clock),
         .reset   (reset),
         .i_sync  (r_sync2[g]),
         .o_strobe(w_strobe[g]),
         .o_busy  (w_busy[g])
      );
   end

   // busy is the pre-transition state, so it reflects earlier presses only
   assign w_blocked[0] = w_busy[1] | w_busy[2];
   assign w_blocked[1] = w_busy[0] | w_busy[2];
   assign w_blocked[2] = w_busy[0] | w_busy[1];
   assign w_live       = w_strobe[2:0] & ~w_blocked;

   always_comb begin
      w_win = 3'b000;
      w_pts = 2'd0;
      if (w_live[2]) begin
         w_win = 3'b100;
         w_pts = 2'd3;
      end else if (w_live[1]) begin
         w_win = 3'b010;
         w_pts = 2'd2;
      end else if (w_live[0]) begin
         w_win = 3'b001;
         w_pts = 2'd1;
      end
   end

   assign w_drop = |(w_strobe[2:0] & ~w_win);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_pts   <= 2'd0;
         r_team  <= 1'b0;
         r_pause <= 1'b0;
         r_ovl   <= 1'b0;
      end else begin
         r_valid <= |w_win;
         r_ovl   <= w_drop;
         r_pause <= r_pause ^ w_strobe[3];
         if (|w_win) begin
            r_pts  <= w_pts;
            r_team <= r_sync2[4];
         end
      end
   end

   assign score_valid = r_valid;
   assign score_pts   = r_pts;
   assign score_team  = r_team;
   assign pause_level = r_pause;
   assign overlap_err = r_ovl;

endmodule

// File: tb/tb_score_input_conditioner.sv
// Bench for score_input_conditioner: directed scenarios plus random
// button activity, checked each cycle against a run-length reference model.

module tb_score_input_conditioner;

   localparam int D = 4;

   logic       clock     = 1'b0;
   logic       reset     = 1'b0;
   logic       btn_one   = 1'b0;
   logic       btn_two   = 1'b0;
   logic       btn_three = 1'b0;
   logic       btn_pause = 1'b0;
   logic       sw_team   = 1'b0;
   logic       score_valid;
   logic [1:0] score_pts;
   logic       score_team;
   logic       pause_level;
   logic       overlap_err;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_ovl = 0;
   int cyc = 0;

   score_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_one    (btn_one),
      .btn_two    (btn_two),
      .btn_three  (btn_three),
      .btn_pause  (btn_pause),
      .sw_team    (sw_team),
      .score_valid(score_valid),
      .score_pts  (score_pts),
      .score_team (score_team),
      .pause_level(pause_level),
      .overlap_err(overlap_err)
   );

   always #5 clock = ~clock;

   // Reference: a press is accepted after D+1 equal synced samples,
   // a release after D+1 low samples while the button counts as down.
   bit         m_s1 [5];
   bit         m_s2 [5];
   bit         m_prev [4];
   bit         m_down [4];
   int         m_run [4];
   bit         st [4];
   bit         busy [4];
   bit         blk;
   bit         drop;
   int         win;
   logic [4:0] raw;
   logic       e_valid = 1'b0;
   logic [1:0] e_pts = 2'd0;
   logic       e_team = 1'b0;
   logic       e_pause = 1'b0;
   logic       e_ovl = 1'b0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 5; i++) begin
            m_s1[i] = 0;
            m_s2[i] = 0;
         end
         for (int i = 0; i < 4; i++) begin
            m_prev[i] = 0;
            m_down[i] = 0;
            m_run[i]  = 0;
         end
         e_valid = 0;
         e_pts   = 0;
         e_team  = 0;
         e_pause = 0;
         e_ovl   = 0;
      end else begin
         raw = {sw_team, btn_pause, btn_three, btn_two, btn_one};
         for (int i = 0; i < 4; i++) begin
            busy[i] = m_down[i];
            st[i]   = 0;
            if (m_s2[i] == m_prev[i]) m_run[i]++;
            else m_run[i] = 1;
            m_prev[i] = m_s2[i];
            if (!m_down[i] && m_s2[i] && m_run[i] == D + 1) begin
               st[i]     = 1;
               m_down[i] = 1;
            end else if (m_down[i] && !m_s2[i] && m_run[i] == D + 1) begin
               m_down[i] = 0;
            end
         end
         win  = -1;
         drop = 0;
         for (int i = 2; i >= 0; i--) begin
            if (st[i]) begin
               blk = 0;
               for (int j = 0; j < 3; j++)
                  if (j != i && busy[j]) blk = 1;
               if (blk || win >= 0) drop = 1;
               else win = i;
            end
         end
         e_valid = (win >= 0);
         if (win >= 0) begin
            e_pts  = 2'(win + 1);
            e_team = m_s2[4];
         end
         e_ovl = drop;
         if (st[3]) e_pause = ~e_pause;
         for (int i = 0; i < 5; i++) begin
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
         end
      end
   end

   function automatic logic [5:0] obs();
      return {score_valid, score_pts, score_team, pause_level, overlap_err};
   endfunction

   function automatic logic [5:0] expv();
      return {e_valid, e_pts, e_team, e_pause, e_ovl};
   endfunction

   task automatic tick();
      @(negedge clock);
      cyc++;
      if (score_valid === 1'b1) n_valid++;
      if (overlap_err === 1'b1) n_ovl++;
   endtask

   task automatic test_reset();
      int first;
      reset     = 1'b0;
      btn_one   = 1'b1;
      btn_two   = 1'b1;
      btn_three = 1'b1;
      btn_pause = 1'b1;
      sw_team   = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (obs() !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b exp %b", obs(), 6'b0);
      end
      reset   = 1'b1;
      n_valid = 0;
      first   = -1;
      tick();
      btn_one   = 1'b0;
      btn_three = 1'b0;
      btn_pause = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_model cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
         if (score_valid === 1'b1 && first < 0) first = k;
      end
      checks++;
      if (first < D + 2) begin
         errors++;
         $display("FAIL reset_quiet first_pulse=%0d required>=%0d", first, D + 2);
      end
      checks++;
      if (n_valid != 1 || score_pts !== 2'd2) begin
         errors++;
         $display("FAIL reset_held_two pulses=%0d pts=%0d required 1/2", n_valid, score_pts);
      end
      btn_two = 1'b0;
      repeat (12) begin
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_settle cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
      end
   endtask

   task automatic test_clean_press();
      int lat;
      sw_team = 1'b1;
      repeat (3) tick();
      btn_three = 1'b1;
      n_valid   = 0;
      lat       = -1;
      for (int k = 1; k <= 32; k++) begin
         if (k == 14) sw_team = 1'b0;
         if (k == 21) btn_three = 1'b0;
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL clean_model cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
         if (score_valid === 1'b1 && lat < 0) lat = k;
      end
      checks++;
      if (lat < D + 3 || lat > D + 5) begin
         errors++;
         $display("FAIL clean_latency got %0d required %0d..%0d", lat, D + 3, D + 5);
      end
      checks++;
      if (n_valid != 1 || score_pts !== 2'd3 || score_team !== 1'b1) begin
         errors++;
         $display("FAIL clean_event pulses=%0d pts=%0d team=%0d required 1/3/1",
                  n_valid, score_pts, score_team);
      end
   endtask

   task automatic test_press_bounce();
      int early;
      n_valid = 0;
      for (int p = 0; p < 8; p++) begin
         btn_one = ((p % 4) < 2);
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL pbounce_model cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
      end
      early = n_valid;
      for (int k = 0; k < 27; k++) begin
         btn_one = (k < 15);
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL pbounce_model cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
      end
      checks++;
      if (early != 0 || n_valid != 1 || score_pts !== 2'd1) begin
         errors++;
         $display("FAIL press_bounce early=%0d pulses=%0d pts=%0d required 0/1/1",
                  early, n_valid, score_pts);
      end
   endtask

   task automatic test_release_bounce();
      n_valid = 0;
      for (int k = 0; k < 38; k++) begin
         btn_two = (k < 12) || (k >= 14 && k < 24);
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL rbounce_model cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
      end
      checks++;
      if (n_valid != 1 || score_pts !== 2'd2) begin
         errors++;
         $display("FAIL release_bounce pulses=%0d pts=%0d required 1/2", n_valid, score_pts);
      end
   endtask

   task automatic test_simultaneous();
      bit same;
      same      = 0;
      n_valid   = 0;
      n_ovl     = 0;
      btn_one   = 1'b1;
      btn_three = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL simul_model cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
         if (score_valid === 1'b1 && overlap_err === 1'b1) same = 1;
      end
      checks++;
      if (n_valid != 1 || score_pts !== 2'd3 || n_ovl != 1 || !same) begin
         errors++;
         $display("FAIL simultaneous pulses=%0d pts=%0d ovl=%0d same=%0d required 1/3/1/1",
                  n_valid, score_pts, n_ovl, same);
      end
      btn_one = 1'b0;
      repeat (10) tick();
      n_valid = 0;
      n_ovl   = 0;
      btn_two = 1'b1;
      for (int k = 0; k < 28; k++) begin
         if (k == 14) begin
            btn_two   = 1'b0;
            btn_three = 1'b0;
         end
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL blocked_model cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
      end
      checks++;
      if (n_valid != 0 || n_ovl != 1 || score_pts !== 2'd3) begin
         errors++;
         $display("FAIL blocked pulses=%0d ovl=%0d pts=%0d required 0/1/3",
                  n_valid, n_ovl, score_pts);
      end
   endtask

   task automatic test_pause();
      n_valid = 0;
      n_ovl   = 0;
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 20; k++) begin
            btn_pause = (k < 10);
            tick();
            checks++;
            if (obs() !== expv()) begin
               errors++;
               $display("FAIL pause_model cyc=%0d got %b exp %b", cyc, obs(), expv());
            end
         end
         checks++;
         if (pause_level !== ((p % 2) == 0)) begin
            errors++;
            $display("FAIL pause_level press=%0d got %b exp %b", p, pause_level, (p % 2) == 0);
         end
      end
      checks++;
      if (n_valid != 0 || n_ovl != 0) begin
         errors++;
         $display("FAIL pause_side pulses=%0d ovl=%0d required 0/0", n_valid, n_ovl);
      end
   endtask

   task automatic test_random();
      int         tmr [5];
      logic [4:0] v;
      v = 5'b0;
      for (int i = 0; i < 5; i++) tmr[i] = 1;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 5; i++) begin
            tmr[i]--;
            if (tmr[i] <= 0) begin
               v[i]   = ~v[i];
               tmr[i] = $urandom_range(0, 1) ? int'($urandom_range(1, 3))
                                             : int'($urandom_range(4, 16));
            end
         end
         {sw_team, btn_pause, btn_three, btn_two, btn_one} = v;
         reset = !(c >= 300 && c < 302);
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL random_model cyc=%0d got %b exp %b", cyc, obs(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_press_bounce();
      test_release_bounce();
      test_simultaneous();
      test_pause();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
